// File: rtl/syst_pkg.sv
// Shared constants and types for the weight-stationary systolic array and its stream controller.
package syst_pkg;

  localparam int unsigned X_WIDTH = 8;
  localparam int unsigned Y_WIDTH = 19;
  localparam int unsigned Y1_LAT  = 3;
  localparam int unsigned Y2_LAT  = 4;

  typedef enum logic [1:0] {
    StIdle,
    StStream,
    StDrain,
    StDone
  } ctrl_state_e;

endpackage

// File: rtl/syst_res_fifo.sv
// Synchronous result FIFO with registered storage, occupancy count and same-cycle push/pop.
module syst_res_fifo #(
  parameter int unsigned WIDTH = 38,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [AW:0]      count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (AW + 1)'(DEPTH));
  assign pop_ok  = pop_i && !empty_o;
  // A pop frees the head slot in the same cycle, so a full FIFO may still take a push.
  assign push_ok = push_i && (!full || pop_ok);
  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_ok && !pop_ok) begin
        count_q <= count_q + 1'b1;
      end else if (pop_ok && !push_ok) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

endmodule

// File: rtl/syst_ws_ctrl.sv
// Stream controller for the 3-in/2-out weight-stationary array: input skew, latency tracking,
// output realignment and a credit-protected result FIFO.
module syst_ws_ctrl import syst_pkg::*; #(
  parameter int unsigned X_WIDTH    = syst_pkg::X_WIDTH,
  parameter int unsigned Y_WIDTH    = syst_pkg::Y_WIDTH,
  parameter int unsigned Y1_LAT     = syst_pkg::Y1_LAT,
  parameter int unsigned Y2_LAT     = syst_pkg::Y2_LAT,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic [LEN_WIDTH-1:0] len_i,
  output logic                 busy_o,
  output logic                 done_o,
  input  logic                 s_valid_i,
  output logic                 s_ready_o,
  input  logic [X_WIDTH-1:0]   s_x1_i,
  input  logic [X_WIDTH-1:0]   s_x2_i,
  input  logic [X_WIDTH-1:0]   s_x3_i,
  output logic [X_WIDTH-1:0]   arr_x1_o,
  output logic [X_WIDTH-1:0]   arr_x2_o,
  output logic [X_WIDTH-1:0]   arr_x3_o,
  input  logic [Y_WIDTH-1:0]   arr_y1_i,
  input  logic [Y_WIDTH-1:0]   arr_y2_i,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic [Y_WIDTH-1:0]   m_y1_o,
  output logic [Y_WIDTH-1:0]   m_y2_o
);

  localparam int unsigned CntW   = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned DlyLen = Y2_LAT - Y1_LAT;

  ctrl_state_e          state_q, state_d;
  logic [LEN_WIDTH-1:0] rem_q, rem_d;
  logic [Y2_LAT-1:0]    vpipe_q, vpipe_d;
  logic [X_WIDTH-1:0]   x2_q, x3_a_q, x3_q;
  logic [CntW-1:0]      inflight, fifo_count, credit_used;
  logic                 s_ready, accept, fifo_empty, fifo_pop;
  logic [Y_WIDTH-1:0]   y1_aligned;
  logic [2*Y_WIDTH-1:0] fifo_head;

  assign accept = s_valid_i && s_ready;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < Y2_LAT; i++) inflight = inflight + CntW'(vpipe_q[i]);
  end

  assign credit_used = inflight + fifo_count;

  // FSM: state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) begin
          rem_d   = len_i;
          state_d = (len_i == '0) ? StDone : StStream;
        end
      end
      StStream: begin
        if (accept) begin
          rem_d = rem_q - 1'b1;
          if (rem_q == LEN_WIDTH'(1)) state_d = StDrain;
        end
      end
      StDrain: begin
        if ((vpipe_q == '0) && fifo_empty) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy_o  = (state_q != StIdle);
    done_o  = (state_q == StDone);
    // Credits cover tokens still in the array, so every emerging result has a FIFO slot.
    s_ready = (state_q == StStream) && (credit_used < CntW'(FIFO_DEPTH));
  end

  assign s_ready_o = s_ready;

  always_comb begin
    vpipe_d[0] = accept;
    for (int i = 1; i < Y2_LAT; i++) vpipe_d[i] = vpipe_q[i-1];
  end

  // Bubbles push zeros through the skew lines so idle array slots always see zero.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vpipe_q <= '0;
      x2_q    <= '0;
      x3_a_q  <= '0;
      x3_q    <= '0;
    end else begin
      vpipe_q <= vpipe_d;
      x2_q    <= accept ? s_x2_i : '0;
      x3_a_q  <= accept ? s_x3_i : '0;
      x3_q    <= x3_a_q;
    end
  end

  assign arr_x1_o = accept ? s_x1_i : '0;
  assign arr_x2_o = x2_q;
  assign arr_x3_o = x3_q;

  if (DlyLen == 0) begin : g_no_dly
    assign y1_aligned = arr_y1_i;
  end else begin : g_dly
    logic [Y_WIDTH-1:0] dly_q [DlyLen];
    logic               tap1;

    assign tap1 = vpipe_q[Y1_LAT-1];

    // Shifts every cycle so y1 stays aligned with its token across bubbles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int i = 0; i < DlyLen; i++) dly_q[i] <= '0;
      end else begin
        dly_q[0] <= tap1 ? arr_y1_i : '0;
        for (int i = 1; i < DlyLen; i++) dly_q[i] <= dly_q[i-1];
      end
    end

    assign y1_aligned = dly_q[DlyLen-1];
  end

  assign fifo_pop = m_valid_o && m_ready_i;

  syst_res_fifo #(
    .WIDTH (2 * Y_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_res_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (vpipe_q[Y2_LAT-1]),
    .data_i  ({y1_aligned, arr_y2_i}),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign m_valid_o = !fifo_empty;
  assign m_y1_o    = fifo_head[2*Y_WIDTH-1:Y_WIDTH];
  assign m_y2_o    = fifo_head[Y_WIDTH-1:0];

endmodule

// File: tb/tb_syst_ws_ctrl.sv
// Randomized scoreboard bench for syst_ws_ctrl with a behavioural array model (W1=(2,3,4),
// W2=(5,6,7)) driven from the skewed array inputs.
module tb_syst_ws_ctrl;

  localparam int XW = 8;
  localparam int YW = 19;
  localparam int DEPTH = 4;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o, done_o;
  logic          s_valid_i = 1'b0;
  logic          s_ready_o;
  logic [XW-1:0] s_x1_i = '0, s_x2_i = '0, s_x3_i = '0;
  logic [XW-1:0] arr_x1_o, arr_x2_o, arr_x3_o;
  logic [YW-1:0] arr_y1_i, arr_y2_i;
  logic          m_valid_o;
  logic          m_ready_i = 1'b1;
  logic [YW-1:0] m_y1_o, m_y2_o;

  always #5 clk = ~clk;

  syst_ws_ctrl #(
    .X_WIDTH    (XW),
    .Y_WIDTH    (YW),
    .Y1_LAT     (3),
    .Y2_LAT     (4),
    .FIFO_DEPTH (DEPTH),
    .LEN_WIDTH  (LW)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .len_i     (len_i),
    .busy_o    (busy_o),
    .done_o    (done_o),
    .s_valid_i (s_valid_i),
    .s_ready_o (s_ready_o),
    .s_x1_i    (s_x1_i),
    .s_x2_i    (s_x2_i),
    .s_x3_i    (s_x3_i),
    .arr_x1_o  (arr_x1_o),
    .arr_x2_o  (arr_x2_o),
    .arr_x3_o  (arr_x3_o),
    .arr_y1_i  (arr_y1_i),
    .arr_y2_i  (arr_y2_i),
    .m_valid_o (m_valid_o),
    .m_ready_i (m_ready_i),
    .m_y1_o    (m_y1_o),
    .m_y2_o    (m_y2_o)
  );

  // Array model: h*[k] holds the array input presented k+1 cycles ago.
  logic [XW-1:0] h1 [4];
  logic [XW-1:0] h2 [4];
  logic [XW-1:0] h3 [4];

  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < 4; k++) begin
        h1[k] <= '0;
        h2[k] <= '0;
        h3[k] <= '0;
      end
    end else begin
      h1[0] <= arr_x1_o;
      h2[0] <= arr_x2_o;
      h3[0] <= arr_x3_o;
      for (int k = 1; k < 4; k++) begin
        h1[k] <= h1[k-1];
        h2[k] <= h2[k-1];
        h3[k] <= h3[k-1];
      end
    end
  end

  assign arr_y1_i = YW'(32'd2 * h1[2] + 32'd3 * h2[1] + 32'd4 * h3[0]);
  assign arr_y2_i = YW'(32'd5 * h1[3] + 32'd6 * h2[2] + 32'd7 * h3[1]);

  function automatic logic [2*YW-1:0] golden(input int x1, input int x2, input int x3);
    int y1, y2;
    y1 = 2 * x1 + 3 * x2 + 4 * x3;
    y2 = 5 * x1 + 6 * x2 + 7 * x3;
    return {YW'(y1), YW'(y2)};
  endfunction

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  logic [2*YW-1:0] exp_q[$];
  int acc_total = 0, pop_total = 0, acc_job = 0, pop_job = 0, job_rem = 0;
  int done_cnt = 0, busy_cnt = 0, valid_cnt = 0;
  logic [XW-1:0] exp2 = '0, exp3a = '0, exp3b = '0;
  int ready_mode = 0;
  bit feed_done = 1'b0;
  bit abort = 1'b0;

  // Monitor / scoreboard
  initial forever begin
    logic acc;
    logic [2*YW-1:0] e;
    @(negedge clk);
    if (!rst_ni) begin
      exp_q.delete();
      exp2 = '0; exp3a = '0; exp3b = '0;
      acc_total = 0; pop_total = 0; job_rem = 0;
    end else begin
      acc = s_valid_i && s_ready_o;
      check("s_ready", 64'(s_ready_o), 64'((job_rem > 0) && (acc_total - pop_total < DEPTH)));
      check("arr_x1", 64'(arr_x1_o), acc ? 64'(s_x1_i) : 64'd0);
      check("arr_x2", 64'(arr_x2_o), 64'(exp2));
      check("arr_x3", 64'(arr_x3_o), 64'(exp3b));
      exp3b = exp3a;
      exp3a = acc ? s_x3_i : '0;
      exp2  = acc ? s_x2_i : '0;
      if (acc) begin
        exp_q.push_back(golden(int'(s_x1_i), int'(s_x2_i), int'(s_x3_i)));
        acc_total++; acc_job++; job_rem--;
      end
      if (m_valid_o && m_ready_i) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("m_y1", 64'(m_y1_o), 64'(e[2*YW-1:YW]));
          check("m_y2", 64'(m_y2_o), 64'(e[YW-1:0]));
        end
        pop_total++; pop_job++;
      end
      if (done_o) done_cnt++;
      if (busy_o) busy_cnt++;
      if (m_valid_o) valid_cnt++;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       m_ready_i = 1'b1;
      1:       m_ready_i = 1'b0;
      default: m_ready_i = ($urandom_range(99) < 70);
    endcase
  end

  task automatic start_job(input int len);
    @(posedge clk); #1;
    start_i = 1'b1;
    len_i = LW'(len);
    @(posedge clk); #1;
    start_i = 1'b0;
    job_rem = len;
    acc_job = 0; pop_job = 0; done_cnt = 0; busy_cnt = 0; valid_cnt = 0;
  endtask

  // mode 0: (1,2,3), mode 1: all 255, mode 2: random; bubble slots carry random junk
  task automatic feed(input int n, input int mode, input int pvalid);
    int got = 0;
    int guard = 0;
    feed_done = 1'b0;
    while (got < n && !abort && guard < 2000) begin
      s_valid_i = ($urandom_range(99) < pvalid);
      if (s_valid_i && mode == 0) begin
        s_x1_i = 8'd1; s_x2_i = 8'd2; s_x3_i = 8'd3;
      end else if (s_valid_i && mode == 1) begin
        s_x1_i = 8'd255; s_x2_i = 8'd255; s_x3_i = 8'd255;
      end else begin
        s_x1_i = XW'($urandom); s_x2_i = XW'($urandom); s_x3_i = XW'($urandom);
      end
      @(negedge clk);
      if (s_valid_i && s_ready_o && rst_ni) got++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid_i = 1'b0;
    if (guard >= 2000) check("feed_timeout", 64'd0, 64'd1);
    feed_done = 1'b1;
  endtask

  task automatic wait_done(input string name, input int exp_pops);
    int g = 0;
    while (done_cnt == 0 && g < 400) begin
      @(negedge clk); #1;
      g++;
    end
    check({name, "_done_seen"}, 64'(done_cnt > 0), 64'd1);
    repeat (3) @(negedge clk);
    #1;
    check({name, "_done_pulses"}, 64'(done_cnt), 64'd1);
    check({name, "_busy_low"}, 64'(busy_o), 64'd0);
    check({name, "_pops"}, 64'(pop_job), 64'(exp_pops));
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctrl"}, 64'({busy_o, done_o, s_ready_o, m_valid_o, arr_x1_o, arr_x2_o,
                               arr_x3_o}), 64'd0);
    check({name, "_data"}, 64'({m_y1_o, m_y2_o}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int g;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_ni = 1'b1;

    // Single vector with latency
    ready_mode = 0;
    start_job(1);
    s_valid_i = 1'b1;
    s_x1_i = 8'd1; s_x2_i = 8'd2; s_x3_i = 8'd3;
    @(negedge clk);
    check("single_ready", 64'(s_ready_o), 64'd1);
    @(posedge clk); #1;
    s_valid_i = 1'b0;
    lat = 0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (m_valid_o) break;
    end
    check("single_latency", 64'(lat), 64'd5);
    check("single_y1", 64'(m_y1_o), 64'd20);
    check("single_y2", 64'(m_y2_o), 64'd38);
    wait_done("single", 1);

    // Full-scale stream
    start_job(8);
    feed(8, 1, 100);
    wait_done("full", 8);

    // Backpressure: credits stop the source after DEPTH accepts
    ready_mode = 1;
    start_job(8);
    fork
      feed(8, 2, 100);
    join_none
    repeat (15) @(negedge clk);
    #1;
    check("bp_accepts", 64'(acc_job), 64'(DEPTH));
    check("bp_ready_low", 64'(s_ready_o), 64'd0);
    ready_mode = 0;
    g = 0;
    while (!feed_done && g < 500) begin
      @(posedge clk);
      g++;
    end
    check("bp_feed_done", 64'(feed_done), 64'd1);
    wait_done("bp", 8);

    // Zero-length job
    start_job(0);
    wait_done("zero", 0);
    check("zero_busy", 64'(busy_cnt >= 1 && busy_cnt <= 2), 64'd1);
    check("zero_no_valid", 64'(valid_cnt), 64'd0);

    // Reset two cycles after the third accept
    start_job(8);
    fork
      feed(8, 2, 100);
    join_none
    g = 0;
    while (acc_job < 3 && g < 200) begin
      @(negedge clk); #1;
      g++;
    end
    check("rst_third_accept", 64'(acc_job), 64'd3);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    g = 0;
    while (!feed_done && g < 50) begin
      @(posedge clk);
      g++;
    end
    abort = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    start_job(4);
    feed(4, 2, 100);
    wait_done("after_rst", 4);

    // Bubbly input with random sink backpressure
    ready_mode = 2;
    start_job(16);
    feed(16, 2, 50);
    wait_done("bubbly", 16);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
